// File: rtl/n8_pkg.sv
// Shared constants and types for the N8 controller responder and host driver.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Exports: N8_NUM_BITS, button bit indices (A = 7 .. RIGHT = 0), n8_state_e.
package n8_pkg;

  localparam int N8_NUM_BITS = 8;

  // Bit positions inside the serial frame; the MSB leaves first.
  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOADING  = 2'd1,
    ST_SHIFTING = 2'd2
  } n8_state_e;

endpackage

// File: rtl/n8_responder_sync_edge.sv
// Synchronizer chain plus edge detector for one asynchronous input.
// Latency: level/rise/fall valid SYNC_STAGES-1 cycles after the first sampling edge.
// Backpressure: none; strobes are single-cycle and cannot be stalled.
// Ports: clk, reset (sync, active-high), din (async in),
//        level (synchronized), rise/fall (one-cycle strobes).
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~edge_q;
  assign fall  = ~level & edge_q;

endmodule

// File: rtl/n8_responder.sv
// Serial button responder for an N8-style controller port (latch/pulse protocol).
// Latency: data_out moves SYNC_STAGES+1 cycles after a pulse edge is first sampled.
// Backpressure: none; the host owns timing, a stalled host is cut off by timeout.
// Ports: clk, reset (sync, active-high), latch/pulse (async from host),
//        a..right (buttons, 1 = pressed), data_out (active-low serial bit),
//        busy, frame_done, timeout_err (one-cycle status pulses).
module n8_responder
  import n8_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic latch,
  input  logic pulse,
  input  logic a,
  input  logic b,
  input  logic select,
  input  logic start,
  input  logic up,
  input  logic down,
  input  logic left,
  input  logic right,
  output logic data_out,
  output logic busy,
  output logic frame_done,
  output logic timeout_err
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] LAST_BIT = 4'(N8_NUM_BITS - 1);

  logic latch_lvl, latch_rise, latch_fall;
  logic pulse_lvl, pulse_rise, pulse_fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
    .clk   (clk),
    .reset (reset),
    .din   (latch),
    .level (latch_lvl),
    .rise  (latch_rise),
    .fall  (latch_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pulse_sync (
    .clk   (clk),
    .reset (reset),
    .din   (pulse),
    .level (pulse_lvl),
    .rise  (pulse_rise),
    .fall  (pulse_fall)
  );

  // Latch is handled by level (reload every cycle while high), so its rise
  // strobe and the pulse level/fall are not needed by the FSM.
  logic unused_sync;
  assign unused_sync = latch_rise ^ pulse_lvl ^ pulse_fall;

  logic [N8_NUM_BITS-1:0] buttons;
  always_comb begin
    buttons             = '0;
    buttons[BTN_A]      = a;
    buttons[BTN_B]      = b;
    buttons[BTN_SELECT] = select;
    buttons[BTN_START]  = start;
    buttons[BTN_UP]     = up;
    buttons[BTN_DOWN]   = down;
    buttons[BTN_LEFT]   = left;
    buttons[BTN_RIGHT]  = right;
  end

  n8_state_e              state, state_nxt;
  logic [N8_NUM_BITS-1:0] sr, sr_nxt;
  logic [3:0]             bit_cnt, bit_cnt_nxt;
  logic [IDLE_W-1:0]      idle_cnt, idle_cnt_nxt;
  logic                   done_nxt, tmo_nxt;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    sr_nxt       = sr;
    bit_cnt_nxt  = bit_cnt;
    idle_cnt_nxt = idle_cnt;
    done_nxt     = 1'b0;
    tmo_nxt      = 1'b0;

    // A high latch overrides everything, including an in-flight frame and a
    // coincident pulse rise.
    if (latch_lvl) begin
      state_nxt    = ST_LOADING;
      sr_nxt       = ~buttons;
      bit_cnt_nxt  = '0;
      idle_cnt_nxt = '0;
    end else begin
      unique case (state)
        ST_LOADING: begin
          if (latch_fall) begin
            state_nxt    = ST_SHIFTING;
            idle_cnt_nxt = '0;
          end
        end
        ST_SHIFTING: begin
          if (pulse_rise) begin
            sr_nxt       = {sr[N8_NUM_BITS-2:0], 1'b1};
            bit_cnt_nxt  = bit_cnt + 4'd1;
            idle_cnt_nxt = '0;
            if (bit_cnt == LAST_BIT) begin
              state_nxt = ST_IDLE;
              done_nxt  = 1'b1;
            end
          end else if (idle_cnt == IDLE_LAST) begin
            state_nxt    = ST_IDLE;
            sr_nxt       = '1;
            idle_cnt_nxt = '0;
            tmo_nxt      = 1'b1;
          end else if (idle_cnt != '1) begin
            idle_cnt_nxt = idle_cnt + IDLE_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr          <= '1;
      bit_cnt     <= '0;
      idle_cnt    <= '0;
      data_out    <= 1'b1;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      sr          <= sr_nxt;
      bit_cnt     <= bit_cnt_nxt;
      idle_cnt    <= idle_cnt_nxt;
      data_out    <= sr[N8_NUM_BITS-1];
      frame_done  <= done_nxt;
      timeout_err <= tmo_nxt;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: doc/n8_responder.md
N8_RESPONDER -- requirements
Module: n8_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on each of latch and pulse (range 2..4).
REQ-002 Parameter TIMEOUT_CYCLES, default 50000: clk cycles without a pulse rise in SHIFTING before the frame is aborted (1 ms at 50 MHz).
REQ-003 clk  input  1  the only clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 latch  input  1  asynchronous latch strobe from the host controller driver.
REQ-006 pulse  input  1  asynchronous shift clock from the host controller driver.
REQ-007 a, b, select, start, up, down, left, right  input  1 each  button states, 1 = pressed, sampled on clk.
REQ-008 data_out  output  1  registered serial button bit, active-low (0 = pressed), idle level 1.
REQ-009 busy  output  1  high in the LOADING and SHIFTING states.
REQ-010 frame_done  output  1  one-cycle pulse when the 8th bit has been shifted out.
REQ-011 timeout_err  output  1  one-cycle pulse when a frame is aborted by timeout.

Function
REQ-012 latch and pulse SHALL each pass through SYNC_STAGES flops; an edge flop on the last stage SHALL give a one-cycle rise/fall strobe.
REQ-013 Internal 8-bit shift register sr holds active-low bits, MSB first in order A, B, Select, Start, Up, Down, Left, Right; data_out = sr[7] (registered).
REQ-014 States: IDLE, LOADING, SHIFTING; bit_cnt is 4 bits wide, range 0..8.
REQ-015 Any state, synchronized latch high: state -> LOADING; sr <= inverted {a,b,select,start,up,down,left,right} every cycle; bit_cnt <= 0.
REQ-016 LOADING, latch fall strobe: state -> SHIFTING; sr holds the last loaded value.
REQ-017 SHIFTING, pulse rise: sr <= {sr[6:0],1}; bit_cnt += 1; idle counter cleared.
REQ-018 SHIFTING, pulse rise that takes bit_cnt 7->8: frame_done = 1 on the next cycle; state -> IDLE; data_out = 1 thereafter.
REQ-019 Latency: data_out SHALL change exactly SYNC_STAGES+1 clk cycles after the pulse edge is first sampled.
REQ-020 Pulse rise while latch is synchronized high, or in IDLE: SHALL NOT change bit_cnt or state; in IDLE, sr stays all 1s.
REQ-021 Latch rise mid-SHIFTING: abort the frame without frame_done and reload per REQ-015.
REQ-022 SHIFTING, idle counter reaches TIMEOUT_CYCLES-1 with no pulse rise: state -> IDLE; sr <= 8'hFF; timeout_err pulses for one cycle.
REQ-023 Simultaneous latch rise and pulse rise: the latch rule wins.
REQ-024 The idle counter SHALL be wide enough for TIMEOUT_CYCLES and SHALL saturate, never wrap.
REQ-025 Button inputs SHALL be sampled only while in LOADING; button changes during SHIFTING SHALL NOT affect the frame.

Reset
REQ-026 On reset: state IDLE, sr = 8'hFF, data_out = 1, bit_cnt = 0, idle counter = 0, all sync/edge flops = 0, busy = 0, frame_done = 0, timeout_err = 0.
REQ-027 Reset asserted mid-frame SHALL take priority over every other rule on that cycle; no frame_done or timeout_err pulse follows.

Structure
REQ-028 Shared package n8_pkg SHALL hold N8_NUM_BITS = 8, the button bit-index constants (A = 7 .. RIGHT = 0) and the state enum type; the existing host driver SHALL use the same package.
REQ-029 One sub-module, sync_edge (parameter SYNC_STAGES; outputs level, rise, fall), SHALL be instantiated once for latch and once for pulse.

Verification
REQ-030 Buttons A = 1, Start = 1, others 0; latch 12 us high, then 8 pulses of 6 us -> serial bits 0,1,1,0,1,1,1,1 sampled before each pulse; frame_done pulses once; data_out = 1 afterwards.
REQ-031 Single pulse edge with SYNC_STAGES = 2 -> data_out changes exactly 3 cycles after the edge is first sampled.
REQ-032 Latch, 3 pulses, then 60000 idle cycles -> timeout_err pulses once at idle count 50000; data_out = 1; busy = 0; no frame_done.
REQ-033 Latch, 4 pulses, new latch with Right = 1 -> no frame_done; the next frame shifts out 1,1,1,1,1,1,1,0.
REQ-034 Reset asserted after the 5th pulse -> data_out = 1 and busy = 0 on the next cycle; 3 further pulses produce no frame_done.
REQ-035 10 pulses with no prior latch -> data_out stays 1; busy and frame_done stay 0.
